// File: rtl/uart_receiver_if.sv
// Parallel receive-side bus of the UART receiver: character, error flags,
// overrun pulse and the valid/ready handshake.
interface uart_receiver_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_receiver.sv
// UART receive engine: two-flop synchroniser, mid-bit sampling FSM with
// optional parity and stop check, and a single-entry valid/ready holding register.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter bit          PARITY_EN    = 1'b1,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_i,
  uart_receiver_if.master rx_if
);

  localparam logic [15:0] HalfLoad = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FullLoad = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LastBit  = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0]           sync_vld_q;
  logic                 armed_q;
  logic                 start_edge;

  state_e               state_q;
  logic [15:0]          cnt_q;
  logic [3:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_pend_q, ferr_pend_q, commit_q;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, overrun_q;

  // armed_q only sets once rx_s carries a real high sampled after reset,
  // so a line held low across reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      sync_vld_q <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      if (sync_vld_q[1] && rx_s_q) armed_q <= 1'b1;
    end
  end

  assign start_edge = armed_q & rx_prev_q & ~rx_s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      commit_q    <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_edge) begin
            cnt_q       <= HalfLoad;
            perr_pend_q <= 1'b0;
            state_q     <= StStart;
          end
        end
        StStart: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (rx_s_q) begin
            state_q <= StIdle;
          end else begin
            cnt_q     <= FullLoad;
            bit_idx_q <= '0;
            state_q   <= StData;
          end
        end
        StData: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            cnt_q   <= FullLoad;
            if (bit_idx_q == LastBit) begin
              state_q <= PARITY_EN ? StParity : StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
        end
        StParity: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            perr_pend_q <= ((^shift_q) ^ rx_s_q) != PARITY_ODD;
            cnt_q       <= FullLoad;
            state_q     <= StStop;
          end
        end
        StStop: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            commit_q    <= 1'b1;
            ferr_pend_q <= ~rx_s_q;
            state_q     <= rx_s_q ? StIdle : StBreak;
          end
        end
        StBreak: begin
          if (rx_s_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A commit wins over a same-cycle read: the slot is refilled and stays valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (commit_q) begin
        if (!valid_q || rx_if.rx_ready) begin
          data_q  <= shift_q;
          perr_q  <= perr_pend_q;
          ferr_q  <= ferr_pend_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.overrun    = overrun_q;

endmodule
